stream_fifo: RTL and testbench

Parametrised successor to the basic FIFO buffer, used between audio-pipeline stages that need back-pressure. Adds a valid/ready handshake on both sides, a registered first-word-fall-through output, almost-full/almost-empty thresholds, synchronous flush, and an optional drop-on-full mode with a drop counter.

---
 rtl/stream_fifo_pkg.sv | 16 +
 rtl/stream_fifo_if.sv | 14 +
 rtl/stream_fifo_mem.sv | 38 +++
 rtl/stream_fifo.sv | 146 ++++++++++++++
 tb/tb_stream_fifo.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared FIFO helpers: depth legality check and index width, reused by all FIFO variants.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package stream_fifo_pkg;

    // True when d is a positive power of two.
    function automatic bit is_pow2(input int d);
        return (d > 0) && ((d & (d - 1)) == 0);
    endfunction

    // Pointer width for a power-of-two depth.
    function automatic int idx_width(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream bundle: one producer (master) to one consumer (slave).
// Latency: n/a (wires only).
// Backpressure: consumer holds ready low to stall; a beat transfers when valid && ready at an edge.
// Signals: valid (master->slave), data[DATA_WIDTH] (master->slave), ready (slave->master).
interface stream_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_fifo_mem.sv
// fifo_mem: simple dual-port RAM, DATA_WIDTH x DEPTH, synchronous write, registered read.
// Latency: read data appears one edge after rd_en; write visible to reads from the next edge.
// Backpressure: none; caller guarantees it never reads an address written on the same edge.
// Ports: clk, reset (clears only the read register), wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data.
module fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = idx_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready FIFO with registered first-word-fall-through head, thresholds, flush, drop mode.
// Latency: a push into an empty FIFO is on out_s.data right after that edge; no bubbles at full rate.
// Backpressure: in_s.ready = !full || out_s.ready (combinational via out_s.ready); tied high in drop mode.
// Ports: clk, reset (async, active-high), flush, clear_flags, in_s (slave stream), out_s (master stream),
//        count, almost_full, almost_empty, overflow (sticky), drop_count (saturating).
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int AFULL_LEVEL    = DEPTH - 4,
    parameter int AEMPTY_LEVEL   = 2,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       clear_flags,
    stream_fifo_if.slave               in_s,
    stream_fifo_if.master              out_s,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int               IDX_W     = idx_width(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_CNT   = CNT_W'(2);
    localparam logic [CNT_W-1:0] AFULL_C   = CNT_W'(AFULL_LEVEL);
    localparam logic [CNT_W-1:0] AEMPTY_C  = CNT_W'(AEMPTY_LEVEL);
    localparam bit               DROP_MODE = (DROP_WHEN_FULL != 0);

    generate
        if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
            $error("stream_fifo: DEPTH must be a power of 2 and at least 2");
        end
        if ((AFULL_LEVEL < 1) || (AFULL_LEVEL > DEPTH)) begin : g_bad_afull
            $error("stream_fifo: AFULL_LEVEL must lie in 1..DEPTH");
        end
        if ((AEMPTY_LEVEL < 0) || (AEMPTY_LEVEL > DEPTH - 1)) begin : g_bad_aempty
            $error("stream_fifo: AEMPTY_LEVEL must lie in 0..DEPTH-1");
        end
    endgenerate

    logic [IDX_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      rd_ptr;
    logic [IDX_W-1:0]      rd_nxt;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  bypass;
    logic                  refill;
    logic                  use_byp;
    logic [DATA_WIDTH-1:0] byp_dat;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    assign full         = (count == FULL_CNT);
    assign out_s.valid  = (count != '0);
    assign in_s.ready   = DROP_MODE ? 1'b1 : (!full || out_s.ready);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    // flush swallows any handshake on the same edge, including what would be a drop.
    assign pop    = out_s.valid && out_s.ready && !flush;
    assign push   = in_s.valid && in_s.ready && (!full || pop) && !flush;
    assign drop   = DROP_MODE && in_s.valid && full && !pop && !flush;

    // The head register is fed from two places: straight from in_s.data when the new
    // word becomes the head this edge, otherwise from the RAM slot behind the old head.
    // With count >= 2 that slot was written on an earlier edge, so no read/write clash.
    assign bypass = push && ((count == '0) || ((count == ONE_CNT) && pop));
    assign refill = pop && (count >= TWO_CNT);
    assign rd_nxt = rd_ptr + 1'b1;

    assign out_s.data = use_byp ? byp_dat : ram_rd_data;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (in_s.data),
        .rd_en   (refill),
        .rd_addr (rd_nxt),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            use_byp <= 1'b1;
            byp_dat <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bypass) begin
                byp_dat <= in_s.data;
                use_byp <= 1'b1;
            end else if (refill) begin
                use_byp <= 1'b0;
            end
        end
    end

    // A drop on the same edge as clear_flags restarts the tally at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_flags) begin
                drop_count <= 16'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (clear_flags) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: back-pressure instance plus a drop-mode instance.
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: stimulus drives out_ready directly on each instance.
module tb_stream_fifo;

    logic        clk;
    logic        reset;
    logic        bp_flush, bp_clear;
    logic        dr_flush, dr_clear;
    logic [4:0]  bp_count, dr_count;
    logic        bp_af, bp_ae, bp_ovf;
    logic        dr_af, dr_ae, dr_ovf;
    logic [15:0] bp_dc, dr_dc;

    int n_cmp;
    int n_bad;
    int nxt_pop;

    stream_fifo_if #(.DATA_WIDTH(8)) bp_in  ();
    stream_fifo_if #(.DATA_WIDTH(8)) bp_out ();
    stream_fifo_if #(.DATA_WIDTH(8)) dr_in  ();
    stream_fifo_if #(.DATA_WIDTH(8)) dr_out ();

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .DROP_WHEN_FULL(0)) dut_bp (
        .clk          (clk),
        .reset        (reset),
        .flush        (bp_flush),
        .clear_flags  (bp_clear),
        .in_s         (bp_in),
        .out_s        (bp_out),
        .count        (bp_count),
        .almost_full  (bp_af),
        .almost_empty (bp_ae),
        .overflow     (bp_ovf),
        .drop_count   (bp_dc)
    );

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .DROP_WHEN_FULL(1)) dut_dr (
        .clk          (clk),
        .reset        (reset),
        .flush        (dr_flush),
        .clear_flags  (dr_clear),
        .in_s         (dr_in),
        .out_s        (dr_out),
        .count        (dr_count),
        .almost_full  (dr_af),
        .almost_empty (dr_ae),
        .overflow     (dr_ovf),
        .drop_count   (dr_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bp_flush = 1'b0; bp_clear = 1'b0;
        dr_flush = 1'b0; dr_clear = 1'b0;
        bp_in.valid = 1'b0; bp_in.data = 8'h00; bp_out.ready = 1'b0;
        dr_in.valid = 1'b0; dr_in.data = 8'h00; dr_out.ready = 1'b0;

        // Reset values
        #12;
        chk("rst_count",  32'(bp_count), 0);
        chk("rst_valid",  32'(bp_out.valid), 0);
        chk("rst_data",   32'(bp_out.data), 0);
        chk("rst_ready",  32'(bp_in.ready), 1);
        chk("rst_afull",  32'(bp_af), 0);
        chk("rst_aempty", 32'(bp_ae), 1);
        chk("rst_ovf",    32'(bp_ovf), 0);
        chk("rst_dc",     32'(bp_dc), 0);
        #1 reset = 1'b0;
        tick();

        // Fill 0x00..0x0F with the sink stalled
        bp_in.valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bp_in.data = 8'(i);
            tick();
            chk("fill_count",  32'(bp_count), 32'(i + 1));
            chk("fill_afull",  32'(bp_af), (i + 1 >= 12) ? 1 : 0);
            chk("fill_aempty", 32'(bp_ae), (i + 1 <= 2) ? 1 : 0);
            chk("fill_head",   32'(bp_out.data), 0);
        end
        bp_in.valid = 1'b0;
        #1;
        chk("full_ready", 32'(bp_in.ready), 0);

        // Full: push 0x77 while popping the head
        bp_in.valid = 1'b1; bp_in.data = 8'h77; bp_out.ready = 1'b1;
        #1;
        chk("full_pp_ready", 32'(bp_in.ready), 1);
        tick();
        chk("full_pp_count", 32'(bp_count), 16);
        chk("full_pp_head",  32'(bp_out.data), 32'h01);
        chk("full_pp_dc",    32'(bp_dc), 0);
        chk("full_pp_ovf",   32'(bp_ovf), 0);

        // Drain: 0x01..0x0F then 0x77
        bp_in.valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", 32'(bp_out.valid), 1);
            chk("drain_data",  32'(bp_out.data), (k < 15) ? 32'(k + 1) : 32'h77);
            tick();
            chk("drain_count",  32'(bp_count), 32'(15 - k));
            chk("drain_aempty", 32'(bp_ae), (15 - k <= 2) ? 1 : 0);
        end
        chk("drained_valid", 32'(bp_out.valid), 0);

        // Empty fall-through
        bp_out.ready = 1'b0; bp_in.valid = 1'b1; bp_in.data = 8'hA5;
        tick();
        chk("ft_valid", 32'(bp_out.valid), 1);
        chk("ft_data",  32'(bp_out.data), 32'hA5);
        bp_in.valid = 1'b0; bp_out.ready = 1'b1;
        tick();
        chk("ft_pop_valid", 32'(bp_out.valid), 0);
        chk("ft_pop_count", 32'(bp_count), 0);

        // count = 1 with push and pop on the same edge
        bp_out.ready = 1'b0; bp_in.valid = 1'b1; bp_in.data = 8'h11;
        tick();
        bp_out.ready = 1'b1; bp_in.data = 8'h22;
        tick();
        chk("c1_valid", 32'(bp_out.valid), 1);
        chk("c1_data",  32'(bp_out.data), 32'h22);
        chk("c1_count", 32'(bp_count), 1);
        bp_in.valid = 1'b0;
        tick();
        chk("c1_empty", 32'(bp_count), 0);

        // Flush at count 9 with a simultaneous push
        bp_out.ready = 1'b0; bp_in.valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bp_in.data = 8'(8'h30 + i);
            tick();
        end
        chk("pre_flush_count", 32'(bp_count), 9);
        bp_flush = 1'b1; bp_in.data = 8'h99;
        tick();
        bp_flush = 1'b0; bp_in.valid = 1'b0;
        chk("flush_count", 32'(bp_count), 0);
        chk("flush_valid", 32'(bp_out.valid), 0);
        chk("flush_dc",    32'(bp_dc), 0);
        bp_in.valid = 1'b1; bp_in.data = 8'h5A;
        tick();
        bp_in.valid = 1'b0;
        chk("post_flush_head",  32'(bp_out.data), 32'h5A);
        chk("post_flush_count", 32'(bp_count), 1);
        bp_out.ready = 1'b1;
        tick();
        chk("post_flush_empty", 32'(bp_count), 0);

        // 40 words streamed at full rate with three in flight
        nxt_pop = 0;
        for (int i = 0; i < 40; i++) begin
            bp_in.valid  = 1'b1;
            bp_in.data   = 8'(8'h80 + i);
            bp_out.ready = (i >= 3);
            if (i >= 3) begin
                chk("wrap_data", 32'(bp_out.data), 32'(8'h80 + nxt_pop));
                nxt_pop++;
            end
            tick();
        end
        bp_in.valid = 1'b0; bp_out.ready = 1'b1;
        chk("wrap_level", 32'(bp_count), 3);
        for (int k = 0; k < 3; k++) begin
            chk("wrap_tail", 32'(bp_out.data), 32'(8'h80 + nxt_pop));
            nxt_pop++;
            tick();
        end
        chk("wrap_empty", 32'(bp_count), 0);

        // Asynchronous reset mid-stream at count 5
        bp_out.ready = 1'b0; bp_in.valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bp_in.data = 8'(8'h40 + i);
            tick();
        end
        bp_in.valid = 1'b0;
        chk("pre_rst_count", 32'(bp_count), 5);
        #3 reset = 1'b1;
        #1;
        chk("arst_count",  32'(bp_count), 0);
        chk("arst_valid",  32'(bp_out.valid), 0);
        chk("arst_data",   32'(bp_out.data), 0);
        chk("arst_ready",  32'(bp_in.ready), 1);
        chk("arst_aempty", 32'(bp_ae), 1);
        #2 reset = 1'b0;
        tick();

        // Drop mode: fill, then three writes while full
        dr_out.ready = 1'b0; dr_in.valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dr_in.data = 8'(8'hC0 + i);
            tick();
        end
        chk("dr_full_count", 32'(dr_count), 16);
        chk("dr_full_ready", 32'(dr_in.ready), 1);
        for (int j = 0; j < 3; j++) begin
            dr_in.data = 8'(8'hE0 + j);
            tick();
        end
        dr_in.valid = 1'b0;
        chk("dr_ovf",   32'(dr_ovf), 1);
        chk("dr_dc",    32'(dr_dc), 3);
        chk("dr_count", 32'(dr_count), 16);
        chk("dr_head",  32'(dr_out.data), 32'hC0);
        dr_clear = 1'b1;
        tick();
        chk("clr_ovf", 32'(dr_ovf), 0);
        chk("clr_dc",  32'(dr_dc), 0);
        dr_in.valid = 1'b1; dr_in.data = 8'hEE;
        tick();
        dr_clear = 1'b0; dr_in.valid = 1'b0;
        chk("clr_drop_ovf", 32'(dr_ovf), 1);
        chk("clr_drop_dc",  32'(dr_dc), 1);
        dr_out.ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("dr_drain", 32'(dr_out.data), 32'(8'hC0 + k));
            tick();
        end
        chk("dr_empty", 32'(dr_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
